// File: rtl/seg16_marquee.sv
// Scrolling text marquee on multiplexed 16-segment digits.
// Characters are appended to a message buffer, and the message scrolls with a blank tail.
module seg16_marquee #(
   parameter int unsigned NUM_DIGITS       = 4,
   parameter int unsigned BUF_DEPTH        = 32,
   parameter int unsigned MUX_DIV          = 1000,
   parameter int unsigned SCROLL_DIV       = 64,
   parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_valid,
   input  logic [7:0]                   wr_char,
   output logic                         wr_ready,
   input  logic                         clear,
   input  logic                         scroll_en,
   output logic [$clog2(BUF_DEPTH):0]   msg_len,
   output logic [15:0]                  segments,
   output logic [NUM_DIGITS-1:0]        digit_sel,
   output logic                         frame_pulse
);

   localparam int unsigned AW    = $clog2(BUF_DEPTH);
   localparam int unsigned LEN_W = AW + 1;
   localparam int unsigned LW    = $clog2(BUF_DEPTH + NUM_DIGITS) + 1;
   localparam int unsigned MW    = $clog2(MUX_DIV);
   localparam int unsigned DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned FW    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

   logic [7:0]            buf_mem [BUF_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [MW-1:0]         mux_cnt;
   logic [DW-1:0]         digit_idx;
   logic [FW-1:0]         frame_cnt;
   logic [LW-1:0]         scroll_pos;
   logic                  slot_end;
   logic                  frame_end;
   logic                  scroll_active;
   logic                  wr_fire;
   logic [LW-1:0]         virt_len;
   logic [LW-1:0]         virt_sum;
   logic [LW-1:0]         virt_idx;
   logic [7:0]            cur_char;
   logic [NUM_DIGITS-1:0] sel_on;

   // Decodes a character into its active-low glyph. Each entry is written as the complement of its lit-segment mask.
   function automatic logic [15:0] decode(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
      case (u)
         8'h30: decode = ~16'hFF00;  8'h31: decode = ~16'h3008;
         8'h32: decode = ~16'hEEC0;  8'h33: decode = ~16'hFC40;
         8'h34: decode = ~16'h31C0;  8'h35: decode = ~16'hDDC0;
         8'h36: decode = ~16'hDFC0;  8'h37: decode = ~16'hF000;
         8'h38: decode = ~16'hFFC0;  8'h39: decode = ~16'hFDC0;
         8'h3A: decode = ~16'h0012;  8'h3B: decode = ~16'h0011;
         8'h3C: decode = ~16'h000C;  8'h3D: decode = ~16'h0CC0;
         8'h3E: decode = ~16'h0021;  8'h3F: decode = ~16'hE042;
         8'h40: decode = ~16'hEB50;  8'h41: decode = ~16'hF3C0;
         8'h42: decode = ~16'hFC52;  8'h43: decode = ~16'hCF00;
         8'h44: decode = ~16'hFC12;  8'h45: decode = ~16'hCF80;
         8'h46: decode = ~16'hC380;  8'h47: decode = ~16'hDF40;
         8'h48: decode = ~16'h33C0;  8'h49: decode = ~16'hCC12;
         8'h4A: decode = ~16'h3E00;  8'h4B: decode = ~16'h038C;
         8'h4C: decode = ~16'h0F00;  8'h4D: decode = ~16'h3328;
         8'h4E: decode = ~16'h3324;  8'h4F: decode = ~16'hFF00;
         8'h50: decode = ~16'hE3C0;  8'h51: decode = ~16'hFF04;
         8'h52: decode = ~16'hE3C4;  8'h53: decode = ~16'hDDC0;
         8'h54: decode = ~16'hC012;  8'h55: decode = ~16'h3F00;
         8'h56: decode = ~16'h0309;  8'h57: decode = ~16'h3305;
         8'h58: decode = ~16'h002D;  8'h59: decode = ~16'h002A;
         8'h5A: decode = ~16'hCC09;  8'h5B: decode = ~16'h4412;
         8'h5C: decode = ~16'h0024;  8'h5D: decode = ~16'h8812;
         8'h5E: decode = ~16'h0005;  8'h5F: decode = ~16'h0C00;
         8'h60: decode = ~16'h0020;
         default: decode = 16'hFFFF;
      endcase
   endfunction

   assign slot_end      = (mux_cnt == MW'(MUX_DIV - 1));
   assign frame_end     = slot_end && (digit_idx == DW'(NUM_DIGITS - 1));
   assign wr_ready      = rst_n && !clear && (msg_len < LEN_W'(BUF_DEPTH));
   assign wr_fire       = wr_valid && wr_ready;
   assign scroll_active = scroll_en && (msg_len > LEN_W'(NUM_DIGITS));

   // The virtual message is the stored text followed by NUM_DIGITS blanks.
   assign virt_len = LW'(msg_len) + LW'(NUM_DIGITS);
   assign virt_sum = scroll_pos + LW'(digit_idx);
   assign virt_idx = (virt_sum >= virt_len) ? virt_sum - virt_len : virt_sum;
   assign cur_char = (virt_idx < LW'(msg_len)) ? buf_mem[virt_idx[AW-1:0]] : 8'h20;

   always_comb begin
      sel_on            = '0;
      sel_on[digit_idx] = 1'b1;
   end

   // Multiplex timing is free-running and unaffected by clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mux_cnt     <= '0;
         digit_idx   <= '0;
         frame_pulse <= 1'b0;
      end else begin
         mux_cnt     <= slot_end ? '0 : mux_cnt + MW'(1);
         if (slot_end) begin
            digit_idx <= (digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx + DW'(1);
         end
         frame_pulse <= (mux_cnt == MW'(MUX_DIV - 2)) && (digit_idx == DW'(NUM_DIGITS - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         msg_len    <= '0;
         wr_ptr     <= '0;
         scroll_pos <= '0;
         frame_cnt  <= '0;
      end else begin
         if (wr_fire) begin
            msg_len <= msg_len + LEN_W'(1);
            wr_ptr  <= wr_ptr + AW'(1);
         end
         if (!scroll_active) begin
            scroll_pos <= '0;
            frame_cnt  <= '0;
         end else if (frame_end) begin
            if (frame_cnt == FW'(SCROLL_DIV - 1)) begin
               frame_cnt  <= '0;
               scroll_pos <= (scroll_pos == virt_len - LW'(1)) ? '0 : scroll_pos + LW'(1);
            end else begin
               frame_cnt <= frame_cnt + FW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         buf_mem[wr_ptr] <= wr_char;
      end
   end

   // Digit drive is blanked for the first cycle of every slot to avoid ghosting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         segments  <= 16'hFFFF;
         digit_sel <= SEL_OFF;
      end else begin
         segments  <= decode(cur_char);
         digit_sel <= (mux_cnt == '0) ? SEL_OFF : (DIGIT_ACTIVE_LOW ? ~sel_on : sel_on);
      end
   end

endmodule

// File: tb/tb_seg16_marquee.sv
// Randomized scoreboard bench for seg16_marquee against a message-level reference model.
module tb_seg16_marquee;

   localparam int N     = 4;
   localparam int DEPTH = 8;
   localparam int MDIV  = 4;
   localparam int SDIV  = 1;
   localparam int FRAME = MDIV * N;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_valid = 1'b0;
   logic [7:0]  wr_char = 8'h00;
   logic        wr_ready;
   logic        clear = 1'b0;
   logic        scroll_en = 1'b0;
   logic [3:0]  msg_len;
   logic [15:0] segments;
   logic [N-1:0] digit_sel;
   logic        frame_pulse;

   seg16_marquee #(
      .NUM_DIGITS(N), .BUF_DEPTH(DEPTH), .MUX_DIV(MDIV), .SCROLL_DIV(SDIV), .DIGIT_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
      .clear(clear), .scroll_en(scroll_en), .msg_len(msg_len), .segments(segments),
      .digit_sel(digit_sel), .frame_pulse(frame_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]  seg;
      logic [N-1:0] sel;
      logic         fp;
      int           len;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: the message as a byte queue, time as cycles since reset.
   byte unsigned m_msg[$];
   int  m_cyc = 0;
   int  m_pos = 0;
   int  m_fc  = 0;
   bit  model_live = 1'b0;

   function automatic logic [15:0] ref_glyph(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
      case (u)
         8'h30:   return 16'h00FF;
         8'h31:   return 16'hCFF7;
         8'h41:   return 16'h0C3F;
         8'h48:   return 16'hCC3F;
         default: return 16'hFFFF;
      endcase
   endfunction

   function automatic logic [7:0] view_char(input int v);
      return (v < m_msg.size()) ? 8'(m_msg[v]) : 8'h20;
   endfunction

   always @(posedge clk) begin : model
      exp_t e;
      int   slot;
      int   len_l;
      bit   active;
      bit   frame_end;
      if (!rst_n) begin
         e.seg = 16'hFFFF; e.sel = '1; e.fp = 1'b0; e.len = 0;
         m_msg.delete(); m_cyc = 0; m_pos = 0; m_fc = 0;
         model_live = 1'b1;
         exp_q.push_back(e);
      end else if (model_live) begin
         slot      = (m_cyc / MDIV) % N;
         len_l     = m_msg.size() + N;
         active    = scroll_en && (m_msg.size() > N);
         frame_end = (m_cyc % FRAME) == FRAME - 1;
         e.seg = ref_glyph(view_char((m_pos + slot) % len_l));
         e.sel = ((m_cyc % MDIV) == 0) ? '1 : ~(N'(1) << slot);
         if (clear) begin
            m_msg.delete(); m_pos = 0; m_fc = 0;
         end else begin
            if (!active) begin
               m_pos = 0; m_fc = 0;
            end else if (frame_end) begin
               m_fc++;
               if (m_fc == SDIV) begin
                  m_fc  = 0;
                  m_pos = (m_pos + 1) % len_l;
               end
            end
            if (wr_valid && m_msg.size() < DEPTH) m_msg.push_back(wr_char);
         end
         m_cyc++;
         e.fp  = (m_cyc % FRAME) == FRAME - 1;
         e.len = m_msg.size();
         exp_q.push_back(e);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("segments", 32'(segments), 32'(e.seg));
            check("digit_sel", 32'(digit_sel), 32'(e.sel));
            check("frame_pulse", 32'(frame_pulse), 32'(e.fp));
            check("msg_len", 32'(msg_len), 32'(e.len));
            check("wr_ready", 32'(wr_ready), 32'(rst_n && !clear && (e.len < DEPTH)));
         end else if (model_live) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue, expected one entry at %0t", $time);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic put(input logic [7:0] c);
      wr_valid = 1'b1;
      wr_char  = c;
      step();
      wr_valid = 1'b0;
   endtask

   // Characters whose glyph is defined exactly, plus codes that must decode blank.
   function automatic logic [7:0] rand_char();
      case ($urandom_range(0, 9))
         0: return 8'h30;
         1: return 8'h31;
         2: return 8'h41;
         3: return 8'h48;
         4: return 8'h61;
         5: return 8'h68;
         6: return 8'h20;
         7: return 8'($urandom_range(0, 47));
         8: return 8'($urandom_range(123, 255));
         default: return 8'h7E;
      endcase
   endfunction

   initial begin : stimulus
      step(3);
      rst_n = 1'b1;
      step(2);
      put(8'h31); put(8'h30);
      step(40);
      put(8'h61); put(8'h7E);
      step(20);
      repeat (4) put(rand_char());
      wr_valid = 1'b1;
      wr_char  = 8'h41;
      step(6);
      wr_valid = 1'b0;
      step(20);
      clear = 1'b1; step(); clear = 1'b0;
      put(8'h48); put(8'h41); put(8'h30); put(8'h30); put(8'h30);
      scroll_en = 1'b1;
      step(9 * FRAME + 20);
      step(3 * FRAME + 3);
      scroll_en = 1'b0;
      step(20);
      clear = 1'b1; wr_valid = 1'b1; wr_char = 8'h41;
      step();
      clear = 1'b0; wr_valid = 1'b0;
      step(10);
      repeat (6) put(rand_char());
      scroll_en = 1'b1;
      step(2 * FRAME + 5);
      rst_n = 1'b0; step(2); rst_n = 1'b1;
      step(20);
      for (int ep = 0; ep < 40; ep++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            rst_n = 1'b0; step(2); rst_n = 1'b1;
         end else if (r < 4) begin
            clear    = 1'b1;
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_char  = rand_char();
            step();
            clear    = 1'b0;
            wr_valid = 1'b0;
         end
         repeat ($urandom_range(0, 10)) begin
            wr_valid = ($urandom_range(0, 2) != 0);
            wr_char  = rand_char();
            step();
         end
         wr_valid  = 1'b0;
         scroll_en = ($urandom_range(0, 3) != 0);
         step($urandom_range(10, 200));
      end
      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg16_marquee.md
SEG16_MARQUEE -- requirements
Module: seg16_marquee

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed 16-segment digits (1..16).
REQ-002 SHALL have parameter BUF_DEPTH, default 32, message buffer entries (power of 2, >= NUM_DIGITS).
REQ-003 SHALL have parameter MUX_DIV, default 1000, clk cycles per digit slot (>= 2).
REQ-004 SHALL have parameter SCROLL_DIV, default 64, refresh frames per scroll step (>= 1).
REQ-005 SHALL have parameter DIGIT_ACTIVE_LOW, default 1, digit_sel polarity (1: 0 = digit on).
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-008 SHALL have port wr_valid  input  1  character write request.
REQ-009 SHALL have port wr_char  input  8  ASCII character to append.
REQ-010 SHALL have port wr_ready  output  1  buffer can accept a character.
REQ-011 SHALL have port clear  input  1  synchronous message flush.
REQ-012 SHALL have port scroll_en  input  1  enable scrolling.
REQ-013 SHALL have port msg_len  output  $clog2(BUF_DEPTH)+1  characters stored.
REQ-014 SHALL have port segments  output  16  active-low segments, bit order aabcddefgghijklm (bit 15 = a1).
REQ-015 SHALL have port digit_sel  output  NUM_DIGITS  one-hot digit enable, polarity per DIGIT_ACTIVE_LOW, digit 0 leftmost.
REQ-016 SHALL have port frame_pulse  output  1  one-cycle strobe per completed refresh frame.

Function
REQ-017 Write accepted iff wr_valid && wr_ready; char stored at wr_ptr, wr_ptr and msg_len +1 next cycle.
REQ-018 wr_ready SHALL be 1 iff msg_len < BUF_DEPTH and clear = 0; writes while full are dropped, no state change.
REQ-019 clear SHALL set msg_len, wr_ptr, scroll_pos, frame counter to 0 next cycle; clear wins over a same-cycle write; mux counters unaffected.
REQ-020 mux_cnt SHALL count 0..MUX_DIV-1 and wrap; at wrap digit_idx advances 0..NUM_DIGITS-1 and wraps to 0.
REQ-021 frame_pulse SHALL be 1 for exactly the cycle in which digit_idx wraps NUM_DIGITS-1 -> 0.
REQ-022 Virtual message length L = msg_len + NUM_DIGITS; virtual index v < msg_len reads buffer[v], else blank (space).
REQ-023 Digit i SHALL display virtual index (scroll_pos + i) mod L.
REQ-024 Scrolling active iff scroll_en = 1 and msg_len > NUM_DIGITS; when inactive scroll_pos SHALL be forced to 0 (static, left-justified, unused digits blank).
REQ-025 When active, scroll_pos SHALL advance by 1 on every SCROLL_DIV-th frame_pulse, wrapping L-1 -> 0; frame counter resets when scrolling inactive.
REQ-026 Decode: 0x30-0x60 per team standard 16-segment glyph table; 0x61-0x7A folded to uppercase first; all other codes, incl. space, -> 16'hFFFF.
REQ-027 Glyph examples: "0" = 16'h00FF, "1" = 16'hCFF7, "A" = 16'h0C3F, "H" = 16'hCC3F.
REQ-028 segments and digit_sel SHALL be registered and update in the same cycle, 1 cycle after mux_cnt/digit_idx change.
REQ-029 Anti-ghost: digit_sel SHALL be all-inactive for the first cycle of every digit slot (mux_cnt = 0 registered), active for remaining MUX_DIV-1 cycles.
REQ-030 A write or clear mid-frame SHALL take effect on the next registered digit update; no glitch beyond that slot.

Reset
REQ-031 rst_n = 0 at a rising edge SHALL set msg_len 0, wr_ptr 0, scroll_pos 0, mux_cnt 0, digit_idx 0, frame counter 0.
REQ-032 During reset segments = 16'hFFFF, digit_sel all-inactive, frame_pulse 0, wr_ready 0; wr_ready = 1 first cycle after release.
REQ-033 Reset asserted mid-scroll SHALL discard the message; no partial state survives.

Verification (MUX_DIV=4, NUM_DIGITS=4, SCROLL_DIV=1, BUF_DEPTH=8)
REQ-034 Reset, write "10" -> msg_len 2; digit0 slot segments 16'hCFF7, digit1 16'h00FF, digits 2,3 16'hFFFF; digit_sel inactive on each slot's first cycle.
REQ-035 Write "a" -> displayed as 16'h0C3F; write 0x7E -> 16'hFFFF.
REQ-036 Write 8 chars then wr_valid held -> wr_ready 0, msg_len stays 8, buffer contents unchanged.
REQ-037 Write "HA000" (L=9), scroll_en=1 -> frame_pulse every 16 cycles; scroll_pos 0,1,...,8,0; at pos 8 digit0 blank, digit1 shows "H" (16'hCC3F).
REQ-038 scroll_en dropped at scroll_pos 3 -> scroll_pos 0 next cycle; clear and wr_valid same cycle -> msg_len 0, char not stored.
